// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity selectors and tuser bit positions.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int TUSER_FERR = 0;
  localparam int TUSER_PERR = 1;
endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator: one-cycle tick at BAUD_RATE*OVERSAMPLE average rate.
// Free-running from reset, so tx and rx sides can share the same generator.
module uart_baud_tick #(
  parameter int BAUD_CLOCK_SPEED = 50000000,
  parameter int BAUD_RATE        = 115200,
  parameter int OVERSAMPLE       = 16
) (
  input  logic aclk,
  input  logic arst,
  output logic tick
);
  localparam int W = $clog2(BAUD_CLOCK_SPEED) + 2;
  localparam logic [W-1:0] INC = W'(BAUD_RATE * OVERSAMPLE);
  localparam logic [W-1:0] LIM = W'(BAUD_CLOCK_SPEED);

  logic [W-1:0] acc;
  logic [W-1:0] sum;

  assign sum = acc + INC;

  always_ff @(posedge aclk) begin
    if (arst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= LIM) begin
      acc  <= sum - LIM;
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with 3-sample majority vote, presenting each character as one AXIS beat.
// A character completing while the holding register is still full is dropped and flagged on overrun.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int BAUD_CLOCK_SPEED = 50000000,
  parameter int BAUD_RATE        = 115200,
  parameter int OVERSAMPLE       = 16,
  parameter int PARITY_ENA       = 0,
  parameter int PARITY_TYPE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int DATA_BITS        = 8
) (
  input  logic       aclk,
  input  logic       arst,
  input  logic       rx,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [1:0] m_axis_tuser,
  output logic       overrun
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] VOTE0 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] VOTE1 = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] VOTE2 = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY_TYPE != 0) ? PARITY_ODD : PARITY_EVEN;

  logic        tick;
  logic        rx_meta, rx_s, rx_q;
  uart_state_t state;
  logic [SW-1:0] scnt;
  logic [2:0]  bcnt;
  logic [1:0]  samp;
  logic [7:0]  shreg;
  logic        perr, ferr;
  logic        done;
  logic [7:0]  done_dat;
  logic [1:0]  done_user;
  logic        vote, at_vote, at_end;

  uart_baud_tick #(
    .BAUD_CLOCK_SPEED(BAUD_CLOCK_SPEED),
    .BAUD_RATE       (BAUD_RATE),
    .OVERSAMPLE      (OVERSAMPLE)
  ) u_tick (
    .aclk(aclk),
    .arst(arst),
    .tick(tick)
  );

  assign vote    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign at_vote = tick && (scnt == VOTE2);
  assign at_end  = tick && (scnt == LAST);

  always_ff @(posedge aclk) begin
    if (arst) begin
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      rx_q          <= 1'b1;
      state         <= ST_IDLE;
      scnt          <= '0;
      bcnt          <= '0;
      samp          <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      done          <= 1'b0;
      done_dat      <= '0;
      done_user     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
      done    <= 1'b0;
      overrun <= 1'b0;

      if (tick) scnt <= (scnt == LAST) ? '0 : scnt + 1'b1;
      if (tick && scnt == VOTE0) samp[0] <= rx_s;
      if (tick && scnt == VOTE1) samp[1] <= rx_s;

      case (state)
        ST_IDLE: begin
          if (rx_q && !rx_s) begin
            state <= ST_START;
            scnt  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state <= ST_IDLE;
          end else if (at_end) begin
            state <= ST_DATA;
            bcnt  <= '0;
          end
        end
        ST_DATA: begin
          if (at_vote) shreg[bcnt] <= vote;
          if (at_end) begin
            if (bcnt == LAST_DATA) begin
              state <= (PARITY_ENA != 0) ? ST_PARITY : ST_STOP;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote) perr <= ((^shreg) ^ vote) != PAR_ODD;
          if (at_end) begin
            state <= ST_STOP;
            bcnt  <= '0;
          end
        end
        ST_STOP: begin
          if (at_vote) begin
            if (!vote) ferr <= 1'b1;
            // Leave at the last vote point, not the bit end, to catch a tight next start edge.
            if (bcnt == LAST_STOP) begin
              state                 <= ST_IDLE;
              done                  <= 1'b1;
              done_dat              <= shreg;
              done_user[TUSER_PERR] <= perr;
              done_user[TUSER_FERR] <= ferr | ~vote;
            end
          end else if (at_end) begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (done) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= done_dat;
          m_axis_tuser  <= done_user;
          m_axis_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: an 8N1 instance and an 8E1 instance driven with serial frames.
module tb_uart_rx_axis;
  localparam int BIT = 434;

  logic clk = 1'b0;
  logic arst;
  logic rx0, rx1;
  logic rdy_fix, rand_mode, rnd_rdy;
  logic tready;
  logic [7:0] tdata0, tdata1;
  logic [1:0] tuser0, tuser1;
  logic tvalid0, tvalid1, overrun0, overrun1;

  int checks = 0;
  int errors = 0;
  logic [9:0] rbuf0 [256];
  logic [9:0] rbuf1 [256];
  int rcnt0 = 0, rcnt1 = 0, rd0 = 0, rd1 = 0;
  int ovr0 = 0, ovr1 = 0;

  typedef struct {
    int         dut;
    logic [7:0] d;
    bit         bad_par;
    bit         stop_low;
    logic [7:0] exp_d;
    logic [1:0] exp_u;
  } vec_t;

  always #10 clk = ~clk;

  assign tready = rand_mode ? rnd_rdy : rdy_fix;

  uart_rx_axis u_dut0 (
    .aclk(clk), .arst(arst), .rx(rx0),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
    .m_axis_tuser(tuser0), .overrun(overrun0)
  );

  uart_rx_axis #(.PARITY_ENA(1), .PARITY_TYPE(0)) u_dut1 (
    .aclk(clk), .arst(arst), .rx(rx1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .m_axis_tuser(tuser1), .overrun(overrun1)
  );

  always begin
    @(posedge clk);
    #2;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Beats accepted and overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (tvalid0 && tready && rcnt0 < 256) begin
      rbuf0[rcnt0] = {tuser0, tdata0};
      rcnt0++;
    end
    if (tvalid1 && tready && rcnt1 < 256) begin
      rbuf1[rcnt1] = {tuser1, tdata1};
      rcnt1++;
    end
    if (overrun0) ovr0++;
    if (overrun1) ovr1++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  // Frame: start, 8 data LSB-first, even parity on instance 1, one stop, half-bit idle.
  task automatic send(input int which, input logic [7:0] d, input bit bad_par, input bit stop_low);
    drive(which, 1'b0);
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      wait_cycles(BIT);
    end
    if (which == 1) begin
      drive(which, (^d) ^ bad_par);
      wait_cycles(BIT);
    end
    drive(which, !stop_low);
    wait_cycles(BIT);
    drive(which, 1'b1);
    wait_cycles(BIT / 2);
  endtask

  function automatic int avail(input int which);
    return (which == 0) ? rcnt0 - rd0 : rcnt1 - rd1;
  endfunction

  task automatic check_beat(input int which, input logic [7:0] ed, input logic [1:0] eu, input string nm);
    logic [9:0] b;
    chk({nm, "_present"}, int'(avail(which) >= 1), 1);
    if (avail(which) >= 1) begin
      if (which == 0) begin b = rbuf0[rd0]; rd0++; end
      else begin b = rbuf1[rd1]; rd1++; end
      chk({nm, "_tdata"}, int'(b[7:0]), int'(ed));
      chk({nm, "_tuser"}, int'(b[9:8]), int'(eu));
    end
  endtask

  initial begin
    vec_t vecs[6];
    logic [9:0] expq0[$];
    logic [9:0] expq1[$];
    int base;

    vecs[0] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 2'b00};
    vecs[1] = '{0, 8'hA3, 1'b0, 1'b0, 8'hA3, 2'b00};
    vecs[2] = '{1, 8'h07, 1'b0, 1'b0, 8'h07, 2'b00};
    vecs[3] = '{1, 8'h07, 1'b1, 1'b0, 8'h07, 2'b10};
    vecs[4] = '{0, 8'h3C, 1'b0, 1'b1, 8'h3C, 2'b01};
    vecs[5] = '{0, 8'h11, 1'b0, 1'b0, 8'h11, 2'b00};

    arst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy_fix = 1'b1; rand_mode = 1'b0;
    wait_cycles(5);
    chk("rst_tvalid0", int'(tvalid0), 0);
    chk("rst_tdata0", int'(tdata0), 0);
    chk("rst_tuser0", int'(tuser0), 0);
    chk("rst_overrun0", int'(overrun0), 0);
    chk("rst_tvalid1", int'(tvalid1), 0);
    arst = 1'b0;
    wait_cycles(50);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].dut, vecs[i].d, vecs[i].bad_par, vecs[i].stop_low);
      check_beat(vecs[i].dut, vecs[i].exp_d, vecs[i].exp_u, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_extra", i), avail(vecs[i].dut), 0);
    end
    chk("no_overrun_clean", ovr0 + ovr1, 0);

    // Quarter-bit low glitch on an idle line must not produce a beat.
    rx0 = 1'b0;
    wait_cycles(BIT / 4);
    rx0 = 1'b1;
    wait_cycles(2 * BIT);
    chk("glitch_no_beat", avail(0), 0);
    send(0, 8'h80, 1'b0, 1'b0);
    check_beat(0, 8'h80, 2'b00, "after_glitch");

    // Holding register full: second character dropped with a single overrun pulse.
    rdy_fix = 1'b0;
    base = ovr0;
    send(0, 8'h01, 1'b0, 1'b0);
    send(0, 8'h02, 1'b0, 1'b0);
    chk("ovr_tvalid_held", int'(tvalid0), 1);
    chk("ovr_tdata_held", int'(tdata0), 8'h01);
    chk("ovr_pulses", ovr0 - base, 1);
    rdy_fix = 1'b1;
    wait_cycles(10);
    check_beat(0, 8'h01, 2'b00, "ovr_drain");
    chk("ovr_only_one", avail(0), 0);
    chk("ovr_tvalid_clear", int'(tvalid0), 0);

    // Reset in the middle of 0xFF discards it.
    rx0 = 1'b0;
    wait_cycles(BIT);
    rx0 = 1'b1;
    wait_cycles(3 * BIT);
    arst = 1'b1;
    wait_cycles(3);
    chk("midrst_tvalid", int'(tvalid0), 0);
    chk("midrst_tdata", int'(tdata0), 0);
    arst = 1'b0;
    wait_cycles(6 * BIT);
    chk("midrst_no_beat", avail(0), 0);
    send(0, 8'h42, 1'b0, 1'b0);
    check_beat(0, 8'h42, 2'b00, "post_rst");
    chk("post_rst_extra", avail(0), 0);

    // Random characters on both instances with random backpressure.
    rand_mode = 1'b1;
    fork
      for (int i = 0; i < 4; i++) begin
        logic [7:0] d;
        bit sl;
        d  = 8'($urandom);
        sl = ($urandom_range(0, 3) == 0);
        expq0.push_back({1'b0, sl, d});
        send(0, d, 1'b0, sl);
      end
      for (int i = 0; i < 4; i++) begin
        logic [7:0] d;
        bit sl, bp;
        d  = 8'($urandom);
        sl = ($urandom_range(0, 3) == 0);
        bp = 1'($urandom_range(0, 1));
        expq1.push_back({bp, sl, d});
        send(1, d, bp, sl);
      end
    join
    wait_cycles(200);
    rand_mode = 1'b0;
    wait_cycles(10);
    chk("rnd_count0", avail(0), expq0.size());
    chk("rnd_count1", avail(1), expq1.size());
    foreach (expq0[i]) check_beat(0, expq0[i][7:0], expq0[i][9:8], $sformatf("rnd0_%0d", i));
    foreach (expq1[i]) check_beat(1, expq1[i][7:0], expq1[i][9:8], $sformatf("rnd1_%0d", i));
    chk("rnd_no_overrun", ovr1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
